// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct_mapped
// Brief    : Write-back, write-allocate, direct-mapped byte data cache.
// Revision : 1.0
// ============================================================================
module dcache_direct_mapped #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int TAG_BITS    = 3
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic                                      READ,
    input  logic                                      WRITE,
    input  logic [7:0]                                ADDRESS,
    input  logic [7:0]                                WRITE_DATA,
    output logic [7:0]                                READ_DATA,
    output logic                                      BUSYWAIT,
    output logic                                      MEM_READ,
    output logic                                      MEM_WRITE,
    output logic [TAG_BITS+$clog2(NUM_SETS)-1:0]      MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0]                  MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0]                  MEM_READDATA,
    input  logic                                      MEM_BUSYWAIT
);

    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;

    logic [BLOCK_BITS-1:0] data_mem [NUM_SETS];
    logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid;
    logic [NUM_SETS-1:0]   dirty;

    logic [TAG_BITS-1:0]    addr_tag;
    logic [INDEX_BITS-1:0]  idx;
    logic [OFFSET_BITS-1:0] off;
    logic                   hit;
    logic                   req;
    logic                   write_hit;
    logic                   fill;

    assign addr_tag  = ADDRESS[7 -: TAG_BITS];
    assign idx       = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign off       = ADDRESS[OFFSET_BITS-1:0];
    assign hit       = valid[idx] && (tag_mem[idx] == addr_tag);
    assign req       = READ || WRITE;
    // A simultaneous READ and WRITE is served as a store.
    assign write_hit = (state == IDLE) && WRITE && hit;
    assign fill      = (state == FETCH) && !MEM_BUSYWAIT;

    assign READ_DATA     = data_mem[idx][{off, 3'b000} +: 8];
    assign MEM_WRITEDATA = data_mem[idx];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSYWAIT) next_state = FETCH;
            end
            FETCH: begin
                if (!MEM_BUSYWAIT) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_ADDRESS = {addr_tag, idx};
        case (state)
            IDLE: begin
                // Reset forces the stall low even while the CPU still requests.
                BUSYWAIT = !RESET && req && !hit;
            end
            WRITEBACK: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {tag_mem[idx], idx};
            end
            FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
            end
            default: begin
                BUSYWAIT = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (write_hit) begin
                dirty[idx] <= 1'b1;
            end
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Payload arrays are deliberately left out of reset; valid bits gate them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_mem[idx] <= MEM_READDATA;
            tag_mem[idx]  <= addr_tag;
        end else if (write_hit) begin
            data_mem[idx][{off, 3'b000} +: 8] <= WRITE_DATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_direct_mapped
// Brief    : Self-checking bench for dcache_direct_mapped with a latency memory.
// Revision : 1.0
// ============================================================================
module tb_dcache_direct_mapped;

    localparam int LAT = 5;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITE_DATA;
    logic [7:0]  READ_DATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] mem [64];
    logic        hold_busy;
    int          cnt;
    int          tests;
    int          fails;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        logic        exp_miss;
        logic        exp_wb;
        logic [5:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
        logic [5:0]  exp_fetch_addr;
    } vec_t;

    vec_t vecs [$];
    vec_t post [$];
    vec_t sb   [$];

    dcache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .READ_DATA    (READ_DATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Backing memory: every untouched byte holds its own byte address.
    initial begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        cnt          = 0;
        for (int b = 0; b < 64; b++) begin
            logic [5:0] bb;
            bb     = b[5:0];
            mem[b] = {bb, 2'd3, bb, 2'd2, bb, 2'd1, bb, 2'd0};
        end
        mem[1] = 32'hDDCCBBAA;
        forever begin
            @(negedge CLK);
            if (MEM_READ || MEM_WRITE) begin
                if (MEM_READ) MEM_READDATA = mem[MEM_ADDRESS];
                if (hold_busy || cnt < LAT) begin
                    MEM_BUSYWAIT = 1'b1;
                    if (cnt < LAT) cnt++;
                end else begin
                    MEM_BUSYWAIT = 1'b0;
                    cnt = 0;
                    if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
                end
            end else begin
                MEM_BUSYWAIT = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] exp_data, input logic miss,
                                input logic wb, input logic [5:0] wba,
                                input logic [31:0] wbd, input logic [5:0] fa);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_miss = miss; v.exp_wb = wb;
        v.exp_wb_addr = wba; v.exp_wb_data = wbd; v.exp_fetch_addr = fa;
        return v;
    endfunction

    task automatic do_op(input vec_t v);
        logic        stalled, saw_wb, saw_rd, overlap, timeout;
        logic [5:0]  wba, fa;
        logic [31:0] wbd;
        vec_t        e;
        int          n;
        @(negedge CLK);
        READ = v.rd; WRITE = v.wr; ADDRESS = v.addr; WRITE_DATA = v.wdata;
        sb.push_back(v);
        stalled = 0; saw_wb = 0; saw_rd = 0; overlap = 0; timeout = 0;
        wba = '0; fa = '0; wbd = '0; n = 0;
        forever begin
            #1;
            if (MEM_READ && MEM_WRITE) overlap = 1;
            if (MEM_WRITE) begin saw_wb = 1; wba = MEM_ADDRESS; wbd = MEM_WRITEDATA; end
            if (MEM_READ)  begin saw_rd = 1; fa = MEM_ADDRESS; end
            if (!BUSYWAIT) break;
            stalled = 1;
            n++;
            if (n > 300) begin timeout = 1; break; end
            @(negedge CLK);
        end
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty at completion", v.name);
            return;
        end
        e = sb.pop_front();
        if (timeout) begin
            tests++; fails++;
            $display("FAIL %s_timeout: BUSYWAIT still high after %0d cycles", e.name, n);
        end
        chk({e.name, "_stall"},   {31'd0, stalled}, {31'd0, e.exp_miss});
        chk({e.name, "_fetch"},   {31'd0, saw_rd},  {31'd0, e.exp_miss});
        chk({e.name, "_wb"},      {31'd0, saw_wb},  {31'd0, e.exp_wb});
        chk({e.name, "_overlap"}, {31'd0, overlap}, 32'd0);
        if (e.exp_miss) chk({e.name, "_fetch_addr"}, {26'd0, fa}, {26'd0, e.exp_fetch_addr});
        if (e.exp_wb) begin
            chk({e.name, "_wb_addr"}, {26'd0, wba}, {26'd0, e.exp_wb_addr});
            chk({e.name, "_wb_data"}, wbd, e.exp_wb_data);
        end
        if (e.rd && !e.wr) chk({e.name, "_rdata"}, {24'd0, READ_DATA}, {24'd0, e.exp_data});
    endtask

    initial begin
        tests = 0; fails = 0; hold_busy = 0;
        RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05; WRITE_DATA = 8'h00;

        vecs.push_back(mk("cold_rd_05",     1, 0, 8'h05, 8'h00, 8'hBB, 1, 0, 6'h00, 32'h0,        6'h01));
        vecs.push_back(mk("wr_hit_06",      0, 1, 8'h06, 8'h3C, 8'h00, 0, 0, 6'h00, 32'h0,        6'h00));
        vecs.push_back(mk("rd_hit_06",      1, 0, 8'h06, 8'h00, 8'h3C, 0, 0, 6'h00, 32'h0,        6'h00));
        vecs.push_back(mk("dirty_evict_25", 1, 0, 8'h25, 8'h00, 8'h25, 1, 1, 6'h01, 32'hDD3CBBAA, 6'h09));
        vecs.push_back(mk("clean_miss_10",  1, 0, 8'h10, 8'h00, 8'h10, 1, 0, 6'h00, 32'h0,        6'h04));
        vecs.push_back(mk("wr_hit_13",      0, 1, 8'h13, 8'h77, 8'h00, 0, 0, 6'h00, 32'h0,        6'h00));
        vecs.push_back(mk("rd_hit_13",      1, 0, 8'h13, 8'h00, 8'h77, 0, 0, 6'h00, 32'h0,        6'h00));
        vecs.push_back(mk("evict_33",       1, 0, 8'h33, 8'h00, 8'h33, 1, 1, 6'h04, 32'h77121110, 6'h0C));
        vecs.push_back(mk("refill_13",      1, 0, 8'h13, 8'h00, 8'h77, 1, 0, 6'h00, 32'h0,        6'h04));
        vecs.push_back(mk("rw_miss_E2",     1, 1, 8'hE2, 8'h5A, 8'h00, 1, 0, 6'h00, 32'h0,        6'h38));
        vecs.push_back(mk("rd_hit_E2",      1, 0, 8'hE2, 8'h00, 8'h5A, 0, 0, 6'h00, 32'h0,        6'h00));
        vecs.push_back(mk("rd_hit_E1",      1, 0, 8'hE1, 8'h00, 8'hE1, 0, 0, 6'h00, 32'h0,        6'h00));
        post.push_back(mk("rst_rd_05",      1, 0, 8'h05, 8'h00, 8'hBB, 1, 0, 6'h00, 32'h0,        6'h01));
        post.push_back(mk("rst_rd_E2",      1, 0, 8'hE2, 8'h00, 8'hE2, 1, 0, 6'h00, 32'h0,        6'h38));

        // Reset state with a pending request: no stall, no memory traffic.
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_outputs", {29'd0, BUSYWAIT, MEM_READ, MEM_WRITE}, 32'd0);
        @(negedge CLK);
        READ = 1'b0; RESET = 1'b0;

        foreach (vecs[i]) do_op(vecs[i]);

        // Memory held busy for 40 cycles during a fetch.
        hold_busy = 1;
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h45;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            chk("hold_fetch", {23'd0, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS},
                {23'd0, 1'b1, 1'b1, 1'b0, 6'h11});
        end
        hold_busy = 0;
        @(negedge CLK);
        #1;
        chk("hold_no_early_fill", {31'd0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        #1;
        chk("hold_release_done", {31'd0, BUSYWAIT}, 32'd0);
        chk("hold_release_rdata", {24'd0, READ_DATA}, 32'h45);

        // Asynchronous reset pulse in the middle of a fetch.
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05;
        repeat (3) @(negedge CLK);
        #1;
        chk("fetch_before_reset", {31'd0, MEM_READ}, 32'd1);
        #1 RESET = 1'b1;
        #1;
        chk("async_reset_drop", {30'd0, BUSYWAIT, MEM_READ}, 32'd0);
        READ = 1'b0;
        #1 RESET = 1'b0;

        foreach (post[i]) do_op(post[i]);

        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
Write-back, write-allocate, direct-mapped data cache between the 8-bit CPU's data port and the 32-bit-block data memory. It serves byte reads and writes from the CPU. On a hit it completes without stalling. On a miss it stalls the CPU through BUSYWAIT while it writes back a dirty victim and fetches the missing block.

Parameters:
NUM_SETS, 8, number of cache lines; 3 index bits.
BLOCK_BYTES, 4, bytes per line; 2 offset bits.
TAG_BITS, 3, tag width; equals 8 - index bits - offset bits.

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
READ  input  1  CPU byte read request.
WRITE  input  1  CPU byte write request.
ADDRESS  input  8  CPU byte address, split as {tag[7:5], index[4:2], offset[1:0]}.
WRITE_DATA  input  8  CPU store data.
READ_DATA  output  8  load data; byte at ADDRESS offset of the indexed line.
BUSYWAIT  output  1  stall to CPU; the CPU holds its PC and request while this is high.
MEM_READ  output  1  memory block read request.
MEM_WRITE  output  1  memory block write request.
MEM_ADDRESS  output  6  memory block address {tag,index}.
MEM_WRITEDATA  output  32  victim block; byte 0 in bits [7:0].
MEM_READDATA  input  32  fetched block; byte 0 in bits [7:0].
MEM_BUSYWAIT  input  1  memory busy; a transfer completes at a posedge sampled with this low.

Behaviour:
- Storage per line: data[31:0], tag[2:0], valid, dirty.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]), computed combinationally.
- States: IDLE, WRITEBACK, FETCH.
- IDLE:
  - BUSYWAIT = (READ | WRITE) & !hit.
  - Read hit: READ_DATA is valid in the same cycle; no memory traffic; no state change.
  - Write hit: the byte at the offset is written at the posedge; dirty is set. Zero stall cycles.
  - Miss, victim valid & dirty: go to WRITEBACK.
  - Miss otherwise: go to FETCH. The transition happens at the posedge.
- WRITEBACK:
  - MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = stored block, BUSYWAIT = 1.
  - At the first posedge with MEM_BUSYWAIT low: go to FETCH.
- FETCH:
  - MEM_READ = 1, MEM_ADDRESS = {ADDRESS tag, index}, BUSYWAIT = 1.
  - At the first posedge with MEM_BUSYWAIT low: data = MEM_READDATA, tag updated, valid = 1, dirty = 0; go to IDLE.
  - The pending access then hits in IDLE and completes as above. Total miss cost = memory latency(s) + 1 cycle.
- MEM_READ and MEM_WRITE are never both high. Both are 0 in IDLE.
- READ and WRITE both high: treated as WRITE.
- Request dropped mid-miss: the current WRITEBACK/FETCH still completes and the line is filled; then return to IDLE.
- The CPU must hold ADDRESS/WRITE_DATA stable while BUSYWAIT is high. A change in FETCH is undefined.
- READ_DATA outside a read: don't-care. It is checked only when READ & !BUSYWAIT.
- RESET asserted (any time, no clock needed):
  - state = IDLE; all valid and dirty bits = 0.
  - MEM_READ = MEM_WRITE = 0, BUSYWAIT = 0.
  - Data and tag arrays are not cleared.
  - An in-flight writeback or fetch is abandoned; dirty data is lost.

Test Plan:
1. Cold read miss: reset, READ ADDRESS=0x05 → BUSYWAIT=1; MEM_READ=1 with MEM_ADDRESS=0x01; memory returns 0xDDCCBBAA after 5 cycles → one cycle later BUSYWAIT=0, READ_DATA=0xBB.
2. Write hit: after scenario 1, WRITE 0x3C to ADDRESS=0x06 → BUSYWAIT stays 0 at the posedge and there is no MEM activity; then READ 0x06 → 0x3C with zero stall.
3. Dirty eviction: READ 0x25 → MEM_WRITE with MEM_ADDRESS=0x01 and MEM_WRITEDATA=0xDD3CBBAA first, then MEM_READ with MEM_ADDRESS=0x09; MEM_READ and MEM_WRITE never overlap.
4. Clean miss on another index: READ 0x10 → straight to FETCH with MEM_ADDRESS=0x04 and no MEM_WRITE.
5. MEM_BUSYWAIT held high for 40 cycles in FETCH → state and MEM_ADDRESS are stable and BUSYWAIT=1 on every cycle; the fill happens only on the cycle after release.
6. Async RESET pulsed between clock edges during FETCH → MEM_READ and BUSYWAIT drop immediately; a subsequent READ 0x05 misses again.
